inv_subbytes_sched: RTL and testbench

Folded inverse-SubBytes engine for the AES decryption datapath. It shares SBOX_LANES INV_sbox instances across the 16 state bytes over several cycles, so it needs fewer S-boxes than the fully parallel 16-instance array. It accepts a 128-bit state as four 32-bit words over a valid/ready handshake and returns the substituted state on a second valid/ready handshake. It sits between the decryption round controller and INV_shiftrows/add-round-key.

---
 rtl/aes_dec_pkg.sv | 50 +++++
 rtl/inv_subbytes_lane.sv | 15 +
 rtl/inv_subbytes_sched.sv | 155 +++++++++++++++
 tb/tb_inv_subbytes_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared AES decryption types, sizes and the GF(2^8) inverse S-box function.
package aes_dec_pkg;

  localparam int AES_STATE_BYTES = 16;
  localparam int AES_WORD_W      = 32;
  localparam int AES_STATE_W     = AES_STATE_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  function automatic int beats_of(input int lanes);
    return AES_STATE_BYTES / lanes;
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

endpackage

// File: rtl/inv_subbytes_lane.sv
// SBOX_LANES parallel inverse S-boxes on a flat byte bus; purely combinational.
module inv_subbytes_lane
  import aes_dec_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input  logic [8*SBOX_LANES-1:0] src,
  output logic [8*SBOX_LANES-1:0] sub
);

  for (genvar i = 0; i < SBOX_LANES; i++) begin : g_sbox
    assign sub[8*i +: 8] = inv_sbox(src[8*i +: 8]);
  end

endmodule

// File: rtl/inv_subbytes_sched.sv
// Folded inverse SubBytes: SBOX_LANES S-boxes swept over the state in BEATS cycles; INV_SUBBYTES_SCHED_PIPE_EN adds a lane output register.
// Result valid BEATS (+1 piped) edges after accept; no new state is taken until the result is consumed.
module inv_subbytes_sched
  import aes_dec_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_WORD_W-1:0] w0,
  input  logic [AES_WORD_W-1:0] w1,
  input  logic [AES_WORD_W-1:0] w2,
  input  logic [AES_WORD_W-1:0] w3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_WORD_W-1:0] w_0,
  output logic [AES_WORD_W-1:0] w_1,
  output logic [AES_WORD_W-1:0] w_2,
  output logic [AES_WORD_W-1:0] w_3,
  output logic                  busy
);

  localparam int BEATS = beats_of(SBOX_LANES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = 8 * SBOX_LANES;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  if (SBOX_LANES != 4 && SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
    $error("inv_subbytes_sched: SBOX_LANES must be 4, 8 or 16");
  end

  sched_state_t           st;
  logic [BW-1:0]          beat;
  logic [AES_STATE_W-1:0] state_q;
  logic [AES_STATE_W-1:0] result_q;
  logic [AES_STATE_W-1:0] out_q;
  logic [LW-1:0]          lane_src;
  logic [LW-1:0]          lane_sub;

  // Replace the lane group selected by b with d, leaving other bytes untouched.
  function automatic logic [AES_STATE_W-1:0] merge(input logic [AES_STATE_W-1:0] r,
                                                   input logic [LW-1:0] d,
                                                   input logic [BW-1:0] b);
    int sh;
    logic [AES_STATE_W-1:0] m;
    sh = int'(b) * LW;
    m  = AES_STATE_W'({LW{1'b1}}) << sh;
    return (r & ~m) | (AES_STATE_W'(d) << sh);
  endfunction

  assign lane_src = LW'(state_q >> (int'(beat) * LW));

  inv_subbytes_lane #(.SBOX_LANES(SBOX_LANES)) u_lane (
    .src(lane_src),
    .sub(lane_sub)
  );

  assign w_0 = out_q[31:0];
  assign w_1 = out_q[63:32];
  assign w_2 = out_q[95:64];
  assign w_3 = out_q[127:96];

`ifdef INV_SUBBYTES_SCHED_PIPE_EN
  logic [LW-1:0] pipe_dat;
  logic [BW-1:0] pipe_beat;
  logic          pipe_vld;
  logic          issue_done;
`endif

  // Outputs are copied from the merged result only on entry to DONE, so a
  // partially written state is never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      beat      <= '0;
      state_q   <= '0;
      result_q  <= '0;
      out_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef INV_SUBBYTES_SCHED_PIPE_EN
      pipe_dat   <= '0;
      pipe_beat  <= '0;
      pipe_vld   <= 1'b0;
      issue_done <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_q  <= {w3, w2, w1, w0};
            result_q <= '0;
            beat     <= '0;
            st       <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef INV_SUBBYTES_SCHED_PIPE_EN
            pipe_vld   <= 1'b0;
            issue_done <= 1'b0;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
`ifdef INV_SUBBYTES_SCHED_PIPE_EN
          pipe_vld <= 1'b0;
          if (!issue_done) begin
            pipe_dat  <= lane_sub;
            pipe_beat <= beat;
            pipe_vld  <= 1'b1;
            if (beat == LAST) begin
              beat       <= '0;
              issue_done <= 1'b1;
            end else begin
              beat <= beat + 1'b1;
            end
          end
          if (pipe_vld) begin
            result_q <= merge(result_q, pipe_dat, pipe_beat);
            if (pipe_beat == LAST) begin
              out_q     <= merge(result_q, pipe_dat, pipe_beat);
              st        <= DONE;
              out_valid <= 1'b1;
            end
          end
`else
          result_q <= merge(result_q, lane_sub, beat);
          if (beat == LAST) begin
            out_q     <= merge(result_q, lane_sub, beat);
            beat      <= '0;
            st        <= DONE;
            out_valid <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_subbytes_sched.sv
// Directed bench for inv_subbytes_sched: latency, byte order, hold, back-to-back, reset, and 8/16-lane configs.
module tb_inv_subbytes_sched;

`ifdef INV_SUBBYTES_SCHED_PIPE_EN
  localparam int LAT4 = 5, LAT8 = 3, LAT16 = 2;
`else
  localparam int LAT4 = 4, LAT8 = 2, LAT16 = 1;
`endif

  // Inputs are bytes of the forward S-box table row 0 / row 1, so outputs are 00..1f.
  localparam logic [127:0] ROW0_IN  = {32'h76abd7fe, 32'h2b670130, 32'hc56f6bf2, 32'h7b777c63};
  localparam logic [127:0] ROW0_OUT = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
  localparam logic [127:0] ROW1_IN  = {32'hc072a49c, 32'hafa2d4ad, 32'hf04759fa, 32'h7dc982ca};
  localparam logic [127:0] ROW1_OUT = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110};
  localparam logic [127:0] V63_IN   = {4{32'h63636363}};
  localparam logic [127:0] V2_IN    = {32'h63636363, 32'h63636363, 32'h63636363, 32'h7c001652};
  localparam logic [127:0] V2_OUT   = {32'h00000000, 32'h00000000, 32'h00000000, 32'h0152ff48};
  localparam logic [127:0] ZERO     = 128'h0;
  localparam logic [127:0] V52      = {4{32'h52525252}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, out_ready, in_valid8, in_valid16;
  logic [31:0] w0, w1, w2, w3;
  logic        in_ready, out_valid, busy;
  logic [31:0] w_0, w_1, w_2, w_3;
  logic        in_ready8, out_valid8, busy8;
  logic [31:0] a_0, a_1, a_2, a_3;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] b_0, b_1, b_2, b_3;
  logic [127:0] res, res8, res16;

  assign res   = {w_3, w_2, w_1, w_0};
  assign res8  = {a_3, a_2, a_1, a_0};
  assign res16 = {b_3, b_2, b_1, b_0};

  inv_subbytes_sched #(.SBOX_LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .out_valid(out_valid), .out_ready(out_ready),
    .w_0(w_0), .w_1(w_1), .w_2(w_2), .w_3(w_3), .busy(busy)
  );
  inv_subbytes_sched #(.SBOX_LANES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .out_valid(out_valid8), .out_ready(out_ready),
    .w_0(a_0), .w_1(a_1), .w_2(a_2), .w_3(a_3), .busy(busy8)
  );
  inv_subbytes_sched #(.SBOX_LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .out_valid(out_valid16), .out_ready(out_ready),
    .w_0(b_0), .w_1(b_1), .w_2(b_2), .w_3(b_3), .busy(busy16)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [127:0] s);
    {w3, w2, w1, w0} = s;
  endtask

  // One transaction on the 4-lane DUT with out_ready high; checks latency, busy span, data.
  task automatic run_one(input string tag, input logic [127:0] din, input logic [127:0] exp);
    int lat;
    int bcnt;
    set_words(din);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (busy) bcnt++;
      if (out_valid && lat == 0) begin
        lat = i;
        chk({tag, "_data"}, res, exp);
      end
      if (!busy) break;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(LAT4));
    chk({tag, "_busy_cycles"}, 128'(bcnt), 128'(LAT4 + 1));
  endtask

  logic [127:0] q_in [3];
  logic [127:0] q_out[3];

  initial begin
    int idx_in, idx_out, last_acc, lat8, lat16;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0; in_valid16 = 1'b0; out_ready = 1'b0;
    set_words(ZERO);
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_words", res, ZERO);
    tick; tick;
    rst_n = 1'b1;
    tick; tick;
    chk("idle_in_ready", 128'(in_ready), 128'(1));
    chk("idle_busy", 128'(busy), 128'(0));

    run_one("all63", V63_IN, ZERO);
    run_one("byte_order", V2_IN, V2_OUT);

    // Consumer stalls in DONE while a second state is offered.
    set_words(ROW0_IN);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick;
    end
    chk("hold_reach_done", 128'(out_valid), 128'(1));
    chk("hold_data", res, ROW0_OUT);
    set_words(ROW1_IN);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hold_out_valid", 128'(out_valid), 128'(1));
      chk("hold_stable", res, ROW0_OUT);
      chk("hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick;
    chk("release_out_valid", 128'(out_valid), 128'(0));
    chk("release_in_ready", 128'(in_ready), 128'(1));
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick;
    end
    chk("after_hold_data", res, ROW1_OUT);
    tick;

    // Back-to-back with in_valid held high.
    q_in[0] = ROW0_IN; q_out[0] = ROW0_OUT;
    q_in[1] = ROW1_IN; q_out[1] = ROW1_OUT;
    q_in[2] = V2_IN;   q_out[2] = V2_OUT;
    idx_in = 0; idx_out = 0; last_acc = 0;
    set_words(q_in[0]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && idx_out < 3; c++) begin
      acc = in_valid && in_ready;
      tick;
      if (acc) begin
        if (idx_in > 0) chk("b2b_spacing", 128'(c - last_acc), 128'(LAT4 + 2));
        last_acc = c;
        idx_in++;
        if (idx_in < 3) set_words(q_in[idx_in]);
        else in_valid = 1'b0;
      end
      if (out_valid && idx_out < 3) begin
        chk("b2b_data", res, q_out[idx_out]);
        idx_out++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", 128'(idx_out), 128'(3));
    tick;

    // Reset in the middle of RUN, at beat 2.
    set_words(ROW0_IN);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    chk("midrst_words", res, ZERO);
    tick;
    rst_n = 1'b1;
    tick; tick;
    chk("postrst_in_ready", 128'(in_ready), 128'(1));
    run_one("zeros", ZERO, V52);

    // 8- and 16-lane configurations on the same state.
    chk("cfg_ready8", 128'(in_ready8), 128'(1));
    chk("cfg_ready16", 128'(in_ready16), 128'(1));
    set_words(ROW0_IN);
    in_valid8 = 1'b1; in_valid16 = 1'b1; out_ready = 1'b1;
    tick;
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    lat8 = 0; lat16 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (out_valid8 && lat8 == 0) begin
        lat8 = i;
        chk("cfg8_data", res8, ROW0_OUT);
      end
      if (out_valid16 && lat16 == 0) begin
        lat16 = i;
        chk("cfg16_data", res16, ROW0_OUT);
      end
      if (lat8 != 0 && lat16 != 0) break;
    end
    chk("cfg8_latency", 128'(lat8), 128'(LAT8));
    chk("cfg16_latency", 128'(lat16), 128'(LAT16));
    tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
